rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit output channel between four byte-wide requesters.
- Drives the select of an internal 4:1 byte mux (mux4_8) and registers the selected byte into an output stage with valid/ready flow control.
- Sits between the storage-system data sources and the single downstream consumer.
- Supports burst retention: a granted requester keeps the channel for up to MAX_BURST accepted bytes.

---
 rtl/rr_mux4_arbiter_pkg.sv | 12 +
 rtl/rr_mux4_arbiter_if.sv | 28 ++
 rtl/mux4_8.sv | 21 ++
 rtl/rr_mux4_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the four-way round-robin byte arbiter.
package rr_mux4_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Requester/consumer bus of the arbiter. The slave side is the arbiter itself;
// the master side drives requests, data bytes and the downstream ready.
interface rr_mux4_arbiter_if;
    import rr_mux4_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [DATA_W-1:0]  d0;
    logic [DATA_W-1:0]  d1;
    logic [DATA_W-1:0]  d2;
    logic [DATA_W-1:0]  d3;
    logic [NUM_REQ-1:0] ack;
    logic [1:0]         sel;
    logic [DATA_W-1:0]  dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               busy;

    modport slave (
        input  req, d0, d1, d2, d3, dout_ready,
        output ack, sel, dout, dout_valid, busy
    );

    modport master (
        output req, d0, d1, d2, d3, dout_ready,
        input  ack, sel, dout, dout_valid, busy
    );

endinterface

// File: rtl/mux4_8.sv
// Plain 4:1 byte multiplexer.
module mux4_8 (
    input  logic [7:0] i_d0,
    input  logic [7:0] i_d1,
    input  logic [7:0] i_d2,
    input  logic [7:0] i_d3,
    input  logic [1:0] i_sel,
    output logic [7:0] o_y
);

    // select one of the four bytes
    always_comb begin
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one registered byte channel between four
// requesters, with burst retention of up to MAX_BURST accepted bytes.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4     // legal range 1..16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux4_arbiter_if.slave bus
);

    localparam int             CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_sel;
    logic [1:0]          w_sel_nxt;
    logic [1:0]          r_ptr;
    logic [1:0]          w_ptr_nxt;
    logic [CW-1:0]       r_beat_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_valid;

    logic [DATA_W-1:0]   w_mux_y;
    logic                w_load_en;
    logic                w_req_g;
    logic                w_ack_fire;
    logic [NUM_REQ-1:0]  w_sel_oh;
    logic                w_release;
    logic                w_excl;
    logic [2:0]          w_pick;

    // Returns {found, index}: first set bit of r scanning p, p+1, ... mod 4.
    // Scanning from the far end lets the nearest hit overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = p + k[1:0];
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    mux4_8 u_mux (
        .i_d0  (bus.d0),
        .i_d1  (bus.d1),
        .i_d2  (bus.d2),
        .i_d3  (bus.d3),
        .i_sel (r_sel),
        .o_y   (w_mux_y)
    );

    assign w_load_en  = !r_dout_valid || bus.dout_ready;
    assign w_req_g    = bus.req[r_sel];
    assign w_ack_fire = (r_state == ST_GRANT) && w_req_g && w_load_en;
    assign w_sel_oh   = 4'b0001 << r_sel;

    assign bus.ack        = w_ack_fire ? w_sel_oh : 4'b0000;
    assign bus.sel        = r_sel;
    assign bus.busy       = (r_state == ST_GRANT);
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;

    // Grant sequencing: pick from IDLE, count beats, release and re-pick in
    // the same edge so a lone requester keeps streaming with no bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_beat_cnt;
        w_release   = 1'b0;
        w_excl      = 1'b0;
        w_pick      = 3'b000;
        case (r_state)
            ST_IDLE: begin
                w_pick = rr_pick(bus.req, r_ptr);
                if (w_pick[2]) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_pick[1:0];
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_ack_fire) begin
                    if (r_beat_cnt == CNT_LAST) w_release = 1'b1;
                    else                        w_cnt_nxt = r_beat_cnt + CW'(1);
                end else if (!w_req_g) begin
                    // voluntary withdrawal: the leaver must not be re-picked
                    w_release = 1'b1;
                    w_excl    = 1'b1;
                end
                if (w_release) begin
                    w_ptr_nxt = r_sel + 2'd1;
                    w_pick    = rr_pick(w_excl ? (bus.req & ~w_sel_oh) : bus.req, r_sel + 2'd1);
                    if (w_pick[2]) begin
                        w_sel_nxt = w_pick[1:0];
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= 2'd0;
            r_ptr      <= 2'd0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    // Output byte stage: load on ack, drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_ack_fire) begin
            r_dout       <= w_mux_y;
            r_dout_valid <= 1'b1;
        end else if (bus.dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_rr_mux4_arbiter;
    import rr_mux4_arbiter_pkg::*;

    localparam int MB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_mux4_arbiter_if bus ();

    rr_mux4_arbiter #(.MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] d [4];

    // behavioural model: owner index, accepted beats in this grant, start pointer
    bit         m_busy;
    int         m_g;
    int         m_ptr;
    int         m_beats;
    logic [7:0] m_dout;
    bit         m_valid;

    logic [3:0] e_ack;
    logic [1:0] o_sel;
    logic [3:0] o_ack;
    logic [7:0] o_dout;
    logic       o_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_beats = 0; m_dout = 8'h00; m_valid = 0;
    endtask

    function automatic logic [3:0] model_ack(input logic [3:0] r, input logic rdy);
        if (m_busy && r[m_g] && (!m_valid || rdy)) return 4'(1 << m_g);
        return 4'b0000;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rdy);
        bit         fire;
        bit         rel;
        bit         excl;
        int         p;
        logic [3:0] rr;
        fire = m_busy && r[m_g] && (!m_valid || rdy);
        if (fire) begin
            m_dout  = d[m_g];
            m_valid = 1;
        end else if (rdy) begin
            m_valid = 0;
        end
        if (!m_busy) begin
            p = pick(r, m_ptr);
            if (p >= 0) begin m_busy = 1; m_g = p; m_beats = 0; end
        end else begin
            rel = 0; excl = 0;
            if (fire) begin
                m_beats++;
                if (m_beats == MB) rel = 1;
            end else if (!r[m_g]) begin
                rel = 1; excl = 1;
            end
            if (rel) begin
                m_ptr = (m_g + 1) % 4;
                rr = r;
                if (excl) rr[m_g] = 1'b0;
                p = pick(rr, m_ptr);
                if (p >= 0) begin m_g = p; m_beats = 0; end
                else m_busy = 0;
            end
        end
    endtask

    // one clock cycle: drive at negedge, compare, advance model at posedge
    task automatic cyc(input logic [3:0] r, input logic rdy);
        @(negedge clk);
        bus.req = r; bus.dout_ready = rdy;
        bus.d0 = d[0]; bus.d1 = d[1]; bus.d2 = d[2]; bus.d3 = d[3];
        #1;
        e_ack = model_ack(r, rdy);
        chk("ack",        32'(bus.ack),        32'(e_ack));
        chk("sel",        32'(bus.sel),        32'(m_g));
        chk("busy",       32'(bus.busy),       32'(m_busy));
        chk("dout",       32'(bus.dout),       32'(m_dout));
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        o_sel = bus.sel; o_ack = bus.ack; o_dout = bus.dout; o_valid = bus.dout_valid;
        @(posedge clk);
        model_step(r, rdy);
    endtask

    // asynchronous reset between edges, outputs checked before any clock edge
    task automatic reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        bus.req = 4'b0000;
        #1;
        chk({tag, "_dout"},  32'(bus.dout),       32'h00);
        chk({tag, "_valid"}, 32'(bus.dout_valid), 32'h0);
        chk({tag, "_busy"},  32'(bus.busy),       32'h0);
        chk({tag, "_ack"},   32'(bus.ack),        32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int         fair_exp [10];
    logic [1:0] bp_sel;
    logic [3:0] cur_r;
    logic [3:0] prev_r;
    logic [3:0] flip;
    logic       rdy;

    initial begin
        fair_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        for (int i = 0; i < 4; i++) d[i] = 8'h00;
        bus.req = 4'b0000; bus.dout_ready = 1'b0;
        bus.d0 = 8'h00; bus.d1 = 8'h00; bus.d2 = 8'h00; bus.d3 = 8'h00;
        model_reset();
        #1;
        chk("init_dout",  32'(bus.dout),       32'h00);
        chk("init_valid", 32'(bus.dout_valid), 32'h0);
        chk("init_busy",  32'(bus.busy),       32'h0);
        chk("init_sel",   32'(bus.sel),        32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // single source, continuous stream through burst rotations
        d[0] = 8'hA5;
        cyc(4'b0001, 1'b1);
        chk("ss_ack_idle", 32'(o_ack), 32'h0);
        cyc(4'b0001, 1'b1);
        chk("ss_ack_first", 32'(o_ack), 32'h1);
        cyc(4'b0001, 1'b1);
        chk("ss_dout", 32'(o_dout), 32'hA5);
        chk("ss_valid", 32'(o_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0001, 1'b1);
            chk("ss_nobubble", 32'(o_ack), 32'h1);
        end

        // reset in the middle of a burst with a byte pending
        reset_check("rst_mid");
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        chk("rst_sel2", 32'(o_sel), 32'h2);

        // fairness with every requester active
        reset_check("rst_fair");
        for (int i = 0; i < 4; i++) d[i] = 8'h3C;
        cyc(4'b1111, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(4'b1111, 1'b1);
            chk("fair_sel", 32'(o_sel), 32'(fair_exp[i]));
        end

        // backpressure holds the stage and the grant
        cyc(4'b1111, 1'b1);
        cyc(4'b1111, 1'b0);
        bp_sel = o_sel;
        chk("bp_ack", 32'(o_ack), 32'h0);
        chk("bp_dout", 32'(o_dout), 32'h3C);
        for (int i = 0; i < 2; i++) begin
            cyc(4'b1111, 1'b0);
            chk("bp_ack", 32'(o_ack), 32'h0);
            chk("bp_dout", 32'(o_dout), 32'h3C);
            chk("bp_sel", 32'(o_sel), 32'(bp_sel));
        end
        cyc(4'b1111, 1'b1);
        chk("bp_resume", 32'(o_ack), 32'(4'b0001 << bp_sel));
        cyc(4'b1111, 1'b1);
        chk("bp_valid", 32'(o_valid), 32'h1);

        // early withdrawal hands straight over, no idle cycle
        reset_check("rst_ew");
        cyc(4'b0110, 1'b1);
        cyc(4'b0110, 1'b1);
        chk("ew_grant1", 32'(o_ack), 32'h2);
        cyc(4'b0100, 1'b1);
        chk("ew_drop", 32'(o_ack), 32'h0);
        cyc(4'b0100, 1'b1);
        chk("ew_sel2", 32'(o_sel), 32'h2);
        chk("ew_ack2", 32'(o_ack), 32'h4);
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        chk("ew_regrant", 32'(o_ack), 32'h4);

        // pointer wrap from 3 back to 0
        reset_check("rst_wrap");
        cyc(4'b1000, 1'b1);
        cyc(4'b1000, 1'b1);
        chk("wrap_ack3", 32'(o_ack), 32'h8);
        cyc(4'b1000, 1'b1);
        cyc(4'b1000, 1'b1);
        chk("wrap_regrant3", 32'(o_sel), 32'h3);
        chk("wrap_regrant_ack", 32'(o_ack), 32'h8);
        cyc(4'b1001, 1'b1);
        cyc(4'b1001, 1'b1);
        chk("wrap_to0", 32'(o_sel), 32'h0);

        // randomized traffic honouring the requester contract
        cur_r  = 4'b1001;
        prev_r = 4'b1001;
        for (int n = 0; n < 800; n++) begin
            flip = 4'b0000;
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) flip[i] = 1'b1;
            cur_r = cur_r ^ flip;
            for (int i = 0; i < 4; i++)
                if (!prev_r[i] || e_ack[i]) d[i] = 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            cyc(cur_r, rdy);
            prev_r = cur_r;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
